// File: rtl/sdes_decrypt_core.sv
// -----------------------------------------------------------------------------
// sdes_decrypt_core
//
// Multi-cycle S-DES decryption engine. A block (8-bit ciphertext plus 10-bit
// key) is taken in over a valid/ready handshake. Both subkeys are derived
// internally. The two Feistel rounds then run in reverse key order (K2, then
// K1), and the 8-bit plaintext is offered on an output valid/ready handshake.
// A single fK datapath is shared by both rounds. The round key is selected
// from the FSM state.
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   clear      in   1   synchronous abort back to IDLE (wins over handshakes)
//   in_valid   in   1   cipher_in / key_in valid
//   in_ready   out  1   core can accept a block (IDLE only)
//   cipher_in  in   8   ciphertext block
//   key_in     in  10   S-DES key
//   out_valid  out  1   plain_out valid
//   out_ready  in   1   consumer accepts plain_out
//   plain_out  out  8   decrypted plaintext, held until the next block completes
//   busy       out  1   high in every state except IDLE
//
// Latency: a block accepted at edge N raises out_valid after edge N+3.
// With out_ready held high the minimum block period is 5 cycles.
// -----------------------------------------------------------------------------
module sdes_decrypt_core (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] cipher_in,
  input  logic [9:0] key_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] plain_out,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KEYGEN = 3'd1,
    R1     = 3'd2,
    R2     = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t     state_reg;
  logic [7:0] cipher_reg;
  logic [9:0] key_reg;
  logic [7:0] data_reg;
  logic [7:0] k1_reg;
  logic [7:0] k2_reg;
  logic [7:0] plain_reg;
  logic       in_ready_reg;
  logic       out_valid_reg;
  logic       busy_reg;

  // ---------------------------------------------------------------------------
  // Fixed S-DES bit shuffles. Position 1 is the MSB, so position p of an n-bit
  // vector lives at index n-p.
  // ---------------------------------------------------------------------------

  // P8 selects positions 6 3 7 4 8 5 10 9 of a 10-bit vector. Positions 1 and 2
  // are never used, so only the low 8 bits are passed in.
  function automatic logic [7:0] p8(input logic [7:0] v);
    return {v[4], v[7], v[3], v[6], v[2], v[5], v[0], v[1]};
  endfunction

  // IP = 2 6 3 1 4 8 5 7
  function automatic logic [7:0] ip(input logic [7:0] v);
    return {v[6], v[2], v[5], v[7], v[4], v[0], v[3], v[1]};
  endfunction

  // IP^-1 = 4 1 3 5 7 2 8 6
  function automatic logic [7:0] ip_inv(input logic [7:0] v);
    return {v[4], v[7], v[5], v[3], v[1], v[6], v[0], v[2]};
  endfunction

  // EP = 4 1 2 3 2 3 4 1 (4-bit to 8-bit expansion)
  function automatic logic [7:0] ep(input logic [3:0] r);
    return {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
  endfunction

  // P4 = 2 4 3 1
  function automatic logic [3:0] p4(input logic [3:0] s);
    return {s[2], s[0], s[1], s[3]};
  endfunction

  // Swap nibbles between the two rounds.
  function automatic logic [7:0] sw(input logic [7:0] v);
    return {v[3:0], v[7:4]};
  endfunction

  // S0: row from bits 1,4 and column from bits 2,3. The case index packs
  // {row, col}, so the entries below read row-major.
  function automatic logic [1:0] sbox0(input logic [3:0] n);
    logic [3:0] addr;
    logic [1:0] val;
    addr = {n[3], n[0], n[2], n[1]};
    case (addr)
      4'd0:    val = 2'd1;
      4'd1:    val = 2'd0;
      4'd2:    val = 2'd3;
      4'd3:    val = 2'd2;
      4'd4:    val = 2'd3;
      4'd5:    val = 2'd2;
      4'd6:    val = 2'd1;
      4'd7:    val = 2'd0;
      4'd8:    val = 2'd0;
      4'd9:    val = 2'd2;
      4'd10:   val = 2'd1;
      4'd11:   val = 2'd3;
      4'd12:   val = 2'd3;
      4'd13:   val = 2'd1;
      4'd14:   val = 2'd3;
      default: val = 2'd2;
    endcase
    return val;
  endfunction

  // S1: same addressing as S0.
  function automatic logic [1:0] sbox1(input logic [3:0] n);
    logic [3:0] addr;
    logic [1:0] val;
    addr = {n[3], n[0], n[2], n[1]};
    case (addr)
      4'd0:    val = 2'd0;
      4'd1:    val = 2'd1;
      4'd2:    val = 2'd2;
      4'd3:    val = 2'd3;
      4'd4:    val = 2'd2;
      4'd5:    val = 2'd0;
      4'd6:    val = 2'd1;
      4'd7:    val = 2'd3;
      4'd8:    val = 2'd3;
      4'd9:    val = 2'd0;
      4'd10:   val = 2'd1;
      4'd11:   val = 2'd0;
      4'd12:   val = 2'd2;
      4'd13:   val = 2'd1;
      4'd14:   val = 2'd0;
      default: val = 2'd3;
    endcase
    return val;
  endfunction

  // Round function F(R, K).
  function automatic logic [3:0] f_round(input logic [3:0] r, input logic [7:0] k);
    logic [7:0] x;
    x = ep(r) ^ k;
    return p4({sbox0(x[7:4]), sbox1(x[3:0])});
  endfunction

  // fK(L, R, K) = (L xor F(R, K), R)
  function automatic logic [7:0] f_k(input logic [7:0] d, input logic [7:0] k);
    return {d[7:4] ^ f_round(d[3:0], k), d[3:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Key schedule, evaluated from the captured key during KEYGEN.
  // ---------------------------------------------------------------------------
  logic [9:0] p10_key;
  logic [4:0] left_ls1;
  logic [4:0] right_ls1;
  logic [7:0] k1_next;
  logic [7:0] k2_next;

  // P10 = 3 5 2 7 4 10 1 9 8 6
  assign p10_key = {key_reg[7], key_reg[5], key_reg[8], key_reg[3], key_reg[6],
                    key_reg[0], key_reg[9], key_reg[1], key_reg[2], key_reg[4]};

  // Each half rotated left by one.
  assign left_ls1  = {p10_key[8:5], p10_key[9]};
  assign right_ls1 = {p10_key[3:0], p10_key[4]};

  assign k1_next = p8({left_ls1[2:0], right_ls1});

  // K2 rotates each half a further two places. Only the bits P8 consumes are
  // formed: low 3 bits of the rotated left half, then all of the right half.
  assign k2_next = p8({left_ls1[0], left_ls1[4:3],
                       right_ls1[2:0], right_ls1[4:3]});

  // ---------------------------------------------------------------------------
  // Shared round datapath. R1 decrypts with K2, and R2 with K1.
  // ---------------------------------------------------------------------------
  logic [7:0] round_key;
  logic [7:0] fk_out;

  assign round_key = (state_reg == R1) ? k2_reg : k1_reg;
  assign fk_out    = f_k(data_reg, round_key);

  // ---------------------------------------------------------------------------
  // Control FSM. in_ready, busy and out_valid are registered alongside the
  // state, so they never glitch. in_ready stays low during reset and comes up
  // on the first edge after release.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cipher_reg    <= '0;
      key_reg       <= '0;
      data_reg      <= '0;
      k1_reg        <= '0;
      k2_reg        <= '0;
      plain_reg     <= '0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else if (clear) begin
      // Abort: any input or output handshake on this edge is discarded.
      state_reg     <= IDLE;
      cipher_reg    <= '0;
      key_reg       <= '0;
      data_reg      <= '0;
      k1_reg        <= '0;
      k2_reg        <= '0;
      plain_reg     <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          in_ready_reg <= 1'b1;
          if (in_valid && in_ready_reg) begin
            cipher_reg   <= cipher_in;
            key_reg      <= key_in;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= KEYGEN;
          end
        end
        KEYGEN: begin
          k1_reg    <= k1_next;
          k2_reg    <= k2_next;
          data_reg  <= ip(cipher_reg);
          state_reg <= R1;
        end
        R1: begin
          data_reg  <= sw(fk_out);
          state_reg <= R2;
        end
        R2: begin
          plain_reg     <= ip_inv(fk_out);
          out_valid_reg <= 1'b1;
          state_reg     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b0;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign plain_out = plain_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_sdes_decrypt_core.sv
// -----------------------------------------------------------------------------
// tb_sdes_decrypt_core
//
// Self-checking bench for sdes_decrypt_core. A table-driven S-DES reference
// model produces the expected plaintexts. Expected results are queued when a
// block is accepted, and popped and compared when the core presents
// out_valid. Each scenario task performs its own comparisons.
// -----------------------------------------------------------------------------
module tb_sdes_decrypt_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] cipher_in = '0;
  logic [9:0] key_in = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] plain_out;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  sdes_decrypt_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cipher_in (cipher_in),
    .key_in    (key_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .plain_out (plain_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Reference model. Each permutation table holds its 1-based positions as hex
  // digits, listed left to right.
  // ---------------------------------------------------------------------------
  localparam logic [39:0] T_P10 = 40'h35274A1986;
  localparam logic [39:0] T_P8  = 40'h00637485A9;
  localparam logic [39:0] T_IP  = 40'h0026314857;
  localparam logic [39:0] T_IPI = 40'h0041357286;
  localparam logic [39:0] T_EP  = 40'h0041232341;
  localparam logic [39:0] T_P4  = 40'h0000002431;

  int s0_tbl [16] = '{1,0,3,2, 3,2,1,0, 0,2,1,3, 3,1,3,2};
  int s1_tbl [16] = '{0,1,2,3, 2,0,1,3, 3,0,1,0, 2,1,0,3};

  function automatic logic [9:0] perm(input logic [9:0] v, input int n,
                                      input logic [39:0] tbl, input int m);
    logic [9:0] r;
    int p;
    r = '0;
    for (int i = 0; i < m; i++) begin
      p = int'(tbl[4*(m-1-i) +: 4]);
      r[m-1-i] = v[n-p];
    end
    return r;
  endfunction

  function automatic logic [3:0] f_m(input logic [3:0] r, input logic [7:0] k);
    logic [9:0] t;
    logic [7:0] e;
    logic [1:0] a, b;
    int row0, col0, row1, col1;
    t = perm({6'd0, r}, 4, T_EP, 8);
    e = t[7:0] ^ k;
    row0 = int'({e[7], e[4]});
    col0 = int'({e[6], e[5]});
    row1 = int'({e[3], e[0]});
    col1 = int'({e[2], e[1]});
    a = 2'(s0_tbl[row0*4 + col0]);
    b = 2'(s1_tbl[row1*4 + col1]);
    t = perm({6'd0, a, b}, 4, T_P4, 4);
    return t[3:0];
  endfunction

  function automatic logic [7:0] crypt_m(input logic [7:0] blk, input logic [9:0] key,
                                         input bit decrypt);
    logic [9:0] t;
    logic [4:0] l, r;
    logic [7:0] k1, k2, ka, kb, d;
    t = perm(key, 10, T_P10, 10);
    l = t[9:5];
    r = t[4:0];
    l = {l[3:0], l[4]};
    r = {r[3:0], r[4]};
    t = perm({l, r}, 10, T_P8, 8);
    k1 = t[7:0];
    l = {l[2:0], l[4:3]};
    r = {r[2:0], r[4:3]};
    t = perm({l, r}, 10, T_P8, 8);
    k2 = t[7:0];
    ka = decrypt ? k2 : k1;
    kb = decrypt ? k1 : k2;
    t = perm({2'b00, blk}, 8, T_IP, 8);
    d = t[7:0];
    d = {d[7:4] ^ f_m(d[3:0], ka), d[3:0]};
    d = {d[3:0], d[7:4]};
    d = {d[7:4] ^ f_m(d[3:0], kb), d[3:0]};
    t = perm({2'b00, d}, 8, T_IPI, 8);
    return t[7:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers: drive and observe only, no comparisons.
  // Both are entered and left at a falling edge.
  // ---------------------------------------------------------------------------
  task automatic drive_block(input logic [7:0] c, input logic [9:0] k,
                             output bit ok, output int acc);
    cipher_in = c;
    key_in    = k;
    in_valid  = 1'b1;
    ok  = 1'b0;
    acc = 0;
    for (int t = 0; t < 20; t++) begin
      if (in_ready === 1'b1) begin
        acc = cyc + 1;
        ok  = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_output(output logic [7:0] v, output bit ok, output int seen);
    ok   = 1'b0;
    v    = '0;
    seen = 0;
    for (int t = 0; t < 20; t++) begin
      if (out_valid === 1'b1) begin
        v    = plain_out;
        seen = cyc;
        ok   = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (plain_out !== 8'h00) begin errors++; $display("FAIL reset_plain_out: got %h expected 00", plain_out); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
    $display("test_reset done");
  endtask

  task automatic test_known_vector();
    bit ok;
    int acc, seen;
    logic [7:0] v, e;
    exp_q.push_back(8'b10010111);
    drive_block(8'b00111000, 10'b1010000010, ok, acc);
    checks++; if (!ok) begin errors++; $display("FAIL kv_accept: got no accept expected accept"); end
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL kv_busy: got in_ready=%b busy=%b expected 0/1", in_ready, busy); end
    @(negedge clk);
    checks++; if (dut.k1_reg !== 8'b10100100) begin errors++; $display("FAIL kv_k1: got %b expected 10100100", dut.k1_reg); end
    checks++; if (dut.k2_reg !== 8'b01000011) begin errors++; $display("FAIL kv_k2: got %b expected 01000011", dut.k2_reg); end
    wait_output(v, ok, seen);
    checks++; if (!ok) begin errors++; $display("FAIL kv_out_timeout: got no out_valid expected out_valid"); end
    checks++; if (seen - acc != 3) begin errors++; $display("FAIL kv_latency: got %0d edges after accept expected 3", seen - acc); end
    e = exp_q.pop_front();
    checks++; if (v !== e) begin errors++; $display("FAIL kv_plain: got %b expected %b", v, e); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL kv_handshake: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    $display("test_known_vector: cipher=00111000 plain=%b", v);
  endtask

  task automatic test_backpressure();
    bit ok;
    int acc, seen;
    logic [7:0] v, e, model;
    logic [9:0] key;
    key   = 10'h2A5;
    model = crypt_m(8'hFF, key, 1'b1);
    exp_q.push_back(model);
    out_ready = 1'b0;
    drive_block(8'hFF, key, ok, acc);
    in_valid = 1'b1;
    checks++; if (!ok) begin errors++; $display("FAIL bp_accept: got no accept expected accept"); end
    wait_output(v, ok, seen);
    checks++; if (!ok) begin errors++; $display("FAIL bp_out_timeout: got no out_valid expected out_valid"); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (plain_out !== model) begin errors++; $display("FAIL bp_hold_plain[%0d]: got %h expected %h", i, plain_out, model); end
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_flags[%0d]: got in_ready=%b out_valid=%b expected 0/1", i, in_ready, out_valid); end
    end
    e = exp_q.pop_front();
    checks++; if (plain_out !== e) begin errors++; $display("FAIL bp_plain: got %h expected %h", plain_out, e); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release: got in_ready=%b out_valid=%b busy=%b expected 1/0/0", in_ready, out_valid, busy); end
    $display("test_backpressure: cipher=ff key=%h plain=%h", key, e);
  endtask

  task automatic test_back_to_back();
    logic [7:0] cv[2], ev[2];
    logic [9:0] kv[2];
    int acc_cyc[2];
    int acc_n, out_n;
    logic [7:0] e;
    cv[0] = 8'b00111000; kv[0] = 10'b1010000010; ev[0] = 8'b10010111;
    kv[1] = 10'b0000000000; ev[1] = 8'hA5; cv[1] = crypt_m(8'hA5, 10'd0, 1'b0);
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    acc_n = 0; out_n = 0;
    cipher_in = cv[0]; key_in = kv[0];
    in_valid = 1'b1; out_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (out_n >= 2) break;
      if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_plain[%0d]: got %h expected nothing", out_n, plain_out); end
        else begin
          e = exp_q.pop_front();
          if (plain_out !== e) begin errors++; $display("FAIL b2b_plain[%0d]: got %h expected %h", out_n, plain_out, e); end
          else $display("test_back_to_back: block %0d plain=%h", out_n, plain_out);
        end
        checks++; if (cyc - acc_cyc[out_n] != 3) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d expected 3", out_n, cyc - acc_cyc[out_n]); end
        out_n++;
      end
      if (in_valid === 1'b1 && in_ready === 1'b1 && acc_n < 2) begin
        acc_cyc[acc_n] = cyc + 1;
        exp_q.push_back(ev[acc_n]);
        acc_n++;
      end
      @(negedge clk);
      if (acc_n == 1) begin cipher_in = cv[1]; key_in = kv[1]; end
      else if (acc_n == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (out_n != 2) begin errors++; $display("FAIL b2b_count: got %0d outputs expected 2", out_n); end
    checks++; if (acc_cyc[1] - acc_cyc[0] != 5) begin errors++; $display("FAIL b2b_period: got %0d expected 5", acc_cyc[1] - acc_cyc[0]); end
  endtask

  task automatic test_clear();
    bit ok, rose;
    int acc, seen;
    logic [7:0] v, e, p;
    logic [9:0] key;
    drive_block(8'h5C, 10'h1F3, ok, acc);
    checks++; if (!ok) begin errors++; $display("FAIL clr_accept: got no accept expected accept"); end
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL clr_flags: got in_ready=%b busy=%b out_valid=%b expected 1/0/0", in_ready, busy, out_valid); end
    checks++; if (dut.k1_reg !== 8'h00 || dut.k2_reg !== 8'h00) begin errors++; $display("FAIL clr_keys: got k1=%h k2=%h expected 00/00", dut.k1_reg, dut.k2_reg); end
    checks++; if (plain_out !== 8'h00) begin errors++; $display("FAIL clr_plain: got %h expected 00", plain_out); end
    rose = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) rose = 1'b1;
    end
    checks++; if (rose) begin errors++; $display("FAIL clr_no_output: got out_valid=1 expected 0"); end
    key = 10'h2B7;
    p   = 8'h3E;
    exp_q.push_back(p);
    drive_block(crypt_m(p, key, 1'b0), key, ok, acc);
    wait_output(v, ok, seen);
    checks++; if (!ok) begin errors++; $display("FAIL clr_next_timeout: got no out_valid expected out_valid"); end
    e = exp_q.pop_front();
    checks++; if (v !== e) begin errors++; $display("FAIL clr_next_plain: got %h expected %h", v, e); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    $display("test_clear: following block plain=%h", v);
  endtask

  task automatic test_async_reset();
    bit ok;
    int acc;
    drive_block(8'hC3, 10'h155, ok, acc);
    checks++; if (!ok) begin errors++; $display("FAIL ar_accept: got no accept expected accept"); end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ar_flags: got out_valid=%b busy=%b expected 0/0", out_valid, busy); end
    checks++; if (plain_out !== 8'h00) begin errors++; $display("FAIL ar_plain: got %h expected 00", plain_out); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ar_in_ready: got %b expected 0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL ar_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
    $display("test_async_reset done");
  endtask

  task automatic test_round_trip();
    bit ok;
    int acc, seen, bad;
    logic [7:0] p, c, v, e;
    logic [9:0] key;
    bad = 0;
    for (int n = 0; n < 512; n++) begin
      key = 10'($urandom_range(0, 1023));
      p   = 8'($urandom_range(0, 255));
      c   = crypt_m(p, key, 1'b0);
      exp_q.push_back(p);
      drive_block(c, key, ok, acc);
      wait_output(v, ok, seen);
      checks++;
      if (!ok) begin errors++; bad++; $display("FAIL rt_timeout[%0d]: got no out_valid expected out_valid", n); end
      e = exp_q.pop_front();
      checks++;
      if (v !== e) begin errors++; bad++; $display("FAIL rt_plain[%0d]: got %h expected %h (key=%h cipher=%h)", n, v, e, key, c); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    $display("test_round_trip: 512 blocks, %0d bad", bad);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_known_vector();
    test_backpressure();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_round_trip();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_empty: got %0d pending expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
